// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared state encoding and register-index constants
package pipeline_hazard_ctrl_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] X0 = '0;
  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs from the pipeline and stage controls back to it
interface pipeline_hazard_ctrl_if;
  import pipeline_hazard_ctrl_pkg::*;
  logic [REG_W-1:0] ifid_rs1;
  logic [REG_W-1:0] ifid_rs2;
  logic ifid_uses_rs1;
  logic ifid_uses_rs2;
  logic [REG_W-1:0] idex_rd;
  logic idex_mem_read;
  logic ex_mispredict;
  logic mem_req;
  logic mem_ready;
  logic pc_en;
  logic ifid_en;
  logic ifid_flush;
  logic idex_en;
  logic idex_clear;
  logic exmem_en;
  modport master (
    output ifid_rs1, ifid_rs2, ifid_uses_rs1, ifid_uses_rs2, idex_rd, idex_mem_read,
           ex_mispredict, mem_req, mem_ready,
    input pc_en, ifid_en, ifid_flush, idex_en, idex_clear, exmem_en
  );
  modport slave (
    input ifid_rs1, ifid_rs2, ifid_uses_rs1, ifid_uses_rs2, idex_rd, idex_mem_read,
          ex_mispredict, mem_req, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_clear, exmem_en
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: saturating up-counter with synchronous active-low clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (!clr) q <= '0;
    else if (inc && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use, memory-stall and mispredict-flush control with perf counters
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  pipeline_hazard_ctrl_if.slave hz,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam logic [3:0] FLOAD = 4'(FLUSH_CYCLES - 1);
  state_t state, state_n;
  logic [3:0] fcnt, fcnt_n;
  logic load_use, freeze, mp_evt;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_clear, exmem_en;
  assign load_use = hz.idex_mem_read && hz.idex_rd != X0 &&
                    ((hz.ifid_uses_rs1 && hz.ifid_rs1 == hz.idex_rd) ||
                     (hz.ifid_uses_rs2 && hz.ifid_rs2 == hz.idex_rd));
  // once waiting, only mem_ready releases the freeze, whatever mem_req does
  assign freeze = (state == MEM_WAIT) ? !hz.mem_ready : hz.mem_req && !hz.mem_ready;
  always_ff @(posedge clk)
    if (!rst) begin
      state <= RUN;
      fcnt <= '0;
    end else begin
      state <= state_n;
      fcnt <= fcnt_n;
    end
  always_comb begin
    state_n = state;
    fcnt_n = fcnt;
    mp_evt = 1'b0;
    {pc_en, ifid_en, ifid_flush, idex_en, idex_clear, exmem_en} = 6'b110101;
    if (freeze) begin
      {pc_en, ifid_en, ifid_flush, idex_en, idex_clear, exmem_en} = 6'b000000;
      state_n = (state == FLUSH) ? FLUSH : MEM_WAIT;
    end else if (hz.ex_mispredict) begin
      {pc_en, ifid_en, ifid_flush, idex_en, idex_clear, exmem_en} = 6'b111111;
      mp_evt = 1'b1;
      state_n = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      fcnt_n = (FLUSH_CYCLES > 1) ? FLOAD : fcnt;
    end else if (state == FLUSH) begin
      {pc_en, ifid_en, ifid_flush, idex_en, idex_clear, exmem_en} = 6'b111111;
      fcnt_n = fcnt - 4'd1;
      state_n = (fcnt <= 4'd1) ? RUN : FLUSH;
    end else begin
      state_n = RUN;
      {pc_en, ifid_en, idex_clear} = load_use ? 3'b001 : 3'b110;
    end
    if (!rst) begin
      {pc_en, ifid_en, ifid_flush, idex_en, idex_clear, exmem_en} = 6'b001010;
      mp_evt = 1'b0;
    end
  end
  assign hz.pc_en = pc_en;
  assign hz.ifid_en = ifid_en;
  assign hz.ifid_flush = ifid_flush;
  assign hz.idex_en = idex_en;
  assign hz.idex_clear = idex_clear;
  assign hz.exmem_en = exmem_en;
  sat_counter #(.W(CNT_W)) u_stall (.clk(clk), .clr(rst), .inc(!pc_en), .q(stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush (.clk(clk), .clr(rst), .inc(mp_evt), .q(flush_cnt));
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed stimulus, per-cycle reference model plus literal spot checks
module tb_pipeline_hazard_ctrl;
  localparam int FC = 3;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int checks = 0;
  int errors = 0;
  pipeline_hazard_ctrl_if hz();
  pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .hz(hz), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_in();
    hz.ifid_rs1 = '0; hz.ifid_rs2 = '0; hz.ifid_uses_rs1 = 0; hz.ifid_uses_rs2 = 0;
    hz.idex_rd = '0; hz.idex_mem_read = 0; hz.ex_mispredict = 0; hz.mem_req = 0; hz.mem_ready = 0;
  endtask
  task automatic do_reset();
    rst = 0;
    tick();
    rst = 1;
  endtask
  // reference model: m_left = flush cycles still owed after the current one
  bit m_wait = 0;
  int m_left = 0;
  int m_sc = 0;
  int m_fc = 0;
  always @(negedge clk) begin
    logic [5:0] e;
    bit frz, lu;
    lu = hz.idex_mem_read && hz.idex_rd != 0 &&
         ((hz.ifid_uses_rs1 && hz.ifid_rs1 == hz.idex_rd) || (hz.ifid_uses_rs2 && hz.ifid_rs2 == hz.idex_rd));
    frz = m_wait ? !hz.mem_ready : (hz.mem_req && !hz.mem_ready);
    if (!rst) e = 6'b001010;
    else if (frz) e = 6'b000000;
    else if (hz.ex_mispredict || m_left > 0) e = 6'b111111;
    else if (lu) e = 6'b000111;
    else e = 6'b110101;
    chk("ctrl", {26'd0, hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_en, hz.idex_clear, hz.exmem_en}, {26'd0, e});
    chk("stall_cnt", {28'd0, stall_cnt}, m_sc);
    chk("flush_cnt", {28'd0, flush_cnt}, m_fc);
    if (!rst) begin
      m_wait = 0; m_left = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (!e[5] && m_sc < CMAX) m_sc++;
      if (frz) m_wait = (m_left == 0);
      else begin
        m_wait = 0;
        if (hz.ex_mispredict) begin
          if (m_fc < CMAX) m_fc++;
          m_left = FC - 1;
        end else if (m_left > 0) m_left--;
      end
    end
  end
  initial begin
    int n;
    clear_in();
    @(negedge clk);
    chk("rst_pc_en", hz.pc_en, 0);
    chk("rst_ifid_flush", hz.ifid_flush, 1);
    chk("rst_idex_clear", hz.idex_clear, 1);
    tick();
    rst = 1;
    hz.idex_mem_read = 1; hz.idex_rd = 5; hz.ifid_rs1 = 5; hz.ifid_uses_rs1 = 1;
    @(negedge clk);
    chk("lu_pc_en", hz.pc_en, 0);
    chk("lu_ifid_en", hz.ifid_en, 0);
    chk("lu_idex_clear", hz.idex_clear, 1);
    tick();
    clear_in();
    @(negedge clk);
    chk("lu_after_pc_en", hz.pc_en, 1);
    chk("lu_stall_cnt", stall_cnt, 1);
    tick();
    hz.idex_mem_read = 1; hz.idex_rd = 0; hz.ifid_rs1 = 0; hz.ifid_uses_rs1 = 1;
    @(negedge clk);
    chk("x0_pc_en", hz.pc_en, 1);
    tick();
    hz.idex_rd = 7; hz.ifid_rs2 = 7; hz.ifid_uses_rs2 = 1; hz.ifid_uses_rs1 = 0;
    tick();
    hz.ifid_uses_rs2 = 0;
    tick();
    clear_in();
    do_reset();
    hz.mem_req = 1;
    repeat (3) tick();
    hz.mem_ready = 1;
    @(negedge clk);
    chk("mem_release_pc_en", hz.pc_en, 1);
    tick();
    clear_in();
    @(negedge clk);
    chk("mem_stall_cnt", stall_cnt, 3);
    do_reset();
    hz.ex_mispredict = 1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (hz.ifid_flush && hz.idex_clear && hz.pc_en) n++;
      tick();
      hz.ex_mispredict = 0;
    end
    chk("flush_window", n, FC);
    chk("flush_cnt_one", flush_cnt, 1);
    do_reset();
    hz.ex_mispredict = 1; hz.mem_req = 1;
    @(negedge clk);
    chk("mp_mem_frozen", hz.pc_en, 0);
    tick();
    tick();
    hz.mem_ready = 1;
    @(negedge clk);
    chk("mp_mem_release_flush", hz.ifid_flush, 1);
    tick();
    clear_in();
    repeat (3) tick();
    hz.ex_mispredict = 1;
    hz.idex_mem_read = 1; hz.idex_rd = 9; hz.ifid_rs1 = 9; hz.ifid_uses_rs1 = 1;
    @(negedge clk);
    chk("mp_lu_pc_en", hz.pc_en, 1);
    chk("mp_lu_flush", hz.ifid_flush, 1);
    tick();
    clear_in();
    repeat (3) tick();
    hz.ex_mispredict = 1;
    tick();
    hz.ex_mispredict = 0;
    tick();
    hz.ex_mispredict = 1;
    tick();
    hz.ex_mispredict = 0;
    repeat (4) tick();
    hz.ex_mispredict = 1;
    tick();
    hz.ex_mispredict = 0; hz.mem_req = 1;
    tick();
    tick();
    hz.mem_ready = 1;
    tick();
    clear_in();
    repeat (4) tick();
    hz.mem_req = 1;
    tick();
    tick();
    rst = 0;
    @(negedge clk);
    chk("rst_wait_clear", hz.idex_clear, 1);
    tick();
    rst = 1; hz.mem_req = 0;
    @(negedge clk);
    chk("rst_wait_pc_en", hz.pc_en, 1);
    chk("rst_wait_stall_cnt", stall_cnt, 0);
    chk("rst_wait_flush_cnt", flush_cnt, 0);
    tick();
    hz.mem_req = 1;
    repeat (20) tick();
    @(negedge clk);
    chk("stall_sat", stall_cnt, CMAX);
    hz.mem_ready = 1;
    tick();
    clear_in();
    repeat (2) tick();
    hz.ex_mispredict = 1;
    tick();
    hz.ex_mispredict = 0; rst = 0;
    tick();
    rst = 1;
    @(negedge clk);
    chk("rst_flush_exit", hz.ifid_flush, 0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Consumer end of the ID/EX hazard interface: takes ID/EX destination/mem-read info, IF/ID source registers, EX branch resolution and the data-memory handshake.
- Drives stage enables, bubble and flush controls for the IF/ID, ID/EX and EX/MEM registers.
- Holds a small state machine for multi-cycle memory stalls and branch-flush windows, plus saturating performance counters.

Parameters:
- FLUSH_CYCLES, 1, total cycles ifid_flush stays asserted per mispredict (1..15).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- ifid_rs1  in  5  rs1 field of instruction in ID
- ifid_rs2  in  5  rs2 field of instruction in ID
- ifid_uses_rs1  in  1  ID instruction reads rs1
- ifid_uses_rs2  in  1  ID instruction reads rs2
- idex_rd  in  5  rd of instruction in EX (ID/EX register read-dest output)
- idex_mem_read  in  1  instruction in EX is a load
- ex_mispredict  in  1  EX resolved branch/jump against prediction (level, held while EX frozen)
- mem_req  in  1  MEM stage has an active data-memory request
- mem_ready  in  1  data memory completes request this cycle
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID load NOP instead of fetched word
- idex_en  out  1  ID/EX load enable
- idex_clear  out  1  ID/EX load bubble (all controls 0)
- exmem_en  out  1  EX/MEM load enable
- stall_cnt  out  CNT_W  cycles with pc_en=0 since reset, saturating
- flush_cnt  out  CNT_W  mispredict events since reset, saturating

Behaviour:
- States: RUN, MEM_WAIT, FLUSH. Register: state, flush counter fcnt (4 bit), stall_cnt, flush_cnt. Control outputs combinational from state + inputs.
- Reset (rst=0 at posedge): state=RUN, fcnt=0, counters=0. While rst=0: pc_en=ifid_en=idex_en=exmem_en=0, ifid_flush=idex_clear=1.
- Default (no event): all enables 1, flushes/clears 0.
- load_use = idex_mem_read && idex_rd!=0 && ((ifid_uses_rs1 && ifid_rs1==idex_rd) || (ifid_uses_rs2 && ifid_rs2==idex_rd)). x0 never hazards.
- Priority per cycle, evaluated in RUN (and in MEM_WAIT on the mem_ready cycle): mem stall > mispredict > load-use.
- Mem stall (mem_req && !mem_ready): pc_en=ifid_en=idex_en=exmem_en=0, no flush/clear; next state MEM_WAIT.
- MEM_WAIT: while mem_ready=0 freeze as above; ex_mispredict and load_use ignored. On mem_ready=1: outputs evaluated as RUN (mispredict/load-use serviced same cycle), next state per RUN rules excluding re-entry to MEM_WAIT from the same request.
- Mispredict: pc_en=1 (redirect), ifid_en=1, ifid_flush=1, idex_clear=1, idex_en=1, exmem_en=1; flush_cnt+1. If FLUSH_CYCLES>1: fcnt=FLUSH_CYCLES-1, next FLUSH; else stay RUN.
- FLUSH: ifid_flush=1, idex_clear=1, all enables 1; fcnt decrements; return to RUN when fcnt reaches 1 at clock edge. Mem stall in FLUSH freezes enables but keeps state/fcnt (flush resumes after). New mispredict in FLUSH reloads fcnt and counts.
- Load-use (RUN, no higher event): pc_en=0, ifid_en=0, idex_clear=1, idex_en=1, exmem_en=1; single bubble, state stays RUN (hazard clears once bubble enters ID/EX).
- stall_cnt increments every cycle pc_en=0 while rst=1; both counters saturate at all-ones, no wrap.
- Reset mid-MEM_WAIT or mid-FLUSH: immediate return to RUN, counters cleared.

Decomposition:
- Shared package: state encoding constants (RUN/MEM_WAIT/FLUSH), register-index width 5, x0 constant.
- One sub-module natural: sat_counter (parameter W, inc, synchronous active-low clear), instantiated twice.

Test Plan:
- Load x5 in EX (idex_mem_read=1, idex_rd=5), ID uses rs1=5 -> one cycle pc_en=0, ifid_en=0, idex_clear=1; next cycle all enables 1; stall_cnt=1.
- idex_rd=0 with load and rs1=0 -> no stall, all enables 1.
- mem_req=1, mem_ready=0 for 3 cycles then 1 -> 3 cycles all enables 0, 4th cycle enables 1, stall_cnt=3.
- FLUSH_CYCLES=3, ex_mispredict pulse -> ifid_flush=1 and idex_clear=1 for exactly 3 cycles, pc_en=1 throughout, flush_cnt=1.
- mispredict + mem stall same cycle, mem_ready after 2 cycles -> 2 frozen cycles, then flush on release cycle; mispredict + load_use same cycle -> flush, no load bubble.
- rst=0 during MEM_WAIT -> next cycle state RUN, counters 0; CNT_W=4 with 20 stall cycles -> stall_cnt=15.
